// File: rtl/four_function_pkg.sv
// Shared types and constants for the four-function lab-logic sweeper.
package four_function_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} sweep_state_t;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;
  localparam int unsigned OUT_W       = 4;
  localparam int unsigned TABLE_W     = 32;
  localparam logic [TABLE_W-1:0] FF_EXPECTED = 32'hF85C5148;
  localparam logic [VEC_W-1:0]   LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/four_function_sweeper_timer.sv
// Settle timer: 8-bit up counter with synchronous clear and a terminal count
// that fires on the last settle cycle of the current vector.
module sweep_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == 8'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/four_function_sweeper.sv
// Drives all 8 {A,B,C} vectors, captures {O4..O1} per vector and compares the
// truth table with EXPECTED. Define SWEEP_ERRCNT_EN to add the err_count output.
module four_function_sweeper
  import four_function_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 2,
  parameter logic [TABLE_W-1:0] EXPECTED      = FF_EXPECTED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [VEC_W-1:0]   abc_out,
  input  logic [OUT_W-1:0]   o_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [VEC_W-1:0]   fail_vec,
  output logic [TABLE_W-1:0] table_out
`ifdef SWEEP_ERRCNT_EN
 ,output logic [3:0]         err_count
`endif
);

  sweep_state_t      state_q;
  logic [VEC_W-1:0]  vec_q;
  logic              fail_q;
  logic              settle_tc;
  logic              timer_clr;
  logic              timer_en;
  logic              mismatch_d;
  logic [OUT_W-1:0]  exp_nib;

  always_comb begin
    exp_nib    = EXPECTED[{vec_q, 2'b00} +: OUT_W];
    mismatch_d = (o_in != exp_nib);
    timer_clr  = ((state_q == IDLE) && start) || (state_q == SAMPLE);
    timer_en   = (state_q == DRIVE);
  end

  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (settle_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      fail_q    <= 1'b0;
      abc_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_vec  <= '0;
      table_out <= '0;
`ifdef SWEEP_ERRCNT_EN
      err_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= DRIVE;
            vec_q     <= '0;
            abc_out   <= '0;
            busy      <= 1'b1;
            fail_q    <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            table_out <= '0;
`ifdef SWEEP_ERRCNT_EN
            err_count <= '0;
`endif
          end
        end
        DRIVE: begin
          if (settle_tc) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_out[{vec_q, 2'b00} +: OUT_W] <= o_in;
          if (mismatch_d && !fail_q) begin
            fail_vec <= vec_q;
            fail_q   <= 1'b1;
          end
`ifdef SWEEP_ERRCNT_EN
          if (mismatch_d) begin
            err_count <= err_count + 4'd1;
          end
`endif
          // pass must already be valid in the done cycle, so fold in this sample
          if (vec_q == LAST_VEC) begin
            state_q <= DONE;
            done    <= 1'b1;
            pass    <= !(fail_q || mismatch_d);
          end else begin
            state_q <= DRIVE;
            vec_q   <= vec_q + 1'b1;
            abc_out <= vec_q + 1'b1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_function_sweeper.sv
// Self-checking bench: three sweepers (SETTLE_CYCLES 2, 1, 5) driven by a lab-logic model.
module tb_four_function_sweeper;

  localparam logic [31:0] GOLD = 32'hF85C5148;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s  [3];
  logic [2:0]  abc_s    [3];
  logic [3:0]  o_in_s   [3];
  logic [3:0]  glitch_s [3];
  logic        busy_s   [3];
  logic        done_s   [3];
  logic        pass_s   [3];
  logic [2:0]  fv_s     [3];
  logic [31:0] tbl_s    [3];
`ifdef SWEEP_ERRCNT_EN
  logic [3:0]  ec_s     [3];
`endif

  logic [7:0]  fmask    [3];
  logic [3:0]  fval     [3][8];
  bit          have_prev[3];
  logic [31:0] prev_tbl [3];
  logic        prev_pass[3];
  logic [2:0]  prev_fv  [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] gold_nib(input logic [2:0] v);
    logic [31:0] g;
    g = GOLD;
    return g[{v, 2'b00} +: 4];
  endfunction

  function automatic int settle(input int j);
    case (j)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  // Lab logic under test: golden table, with per-vector fault overrides and glitches
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      o_in_s[j] = (fmask[j][abc_s[j]] ? fval[j][abc_s[j]] : gold_nib(abc_s[j])) ^ glitch_s[j];
    end
  end

  four_function_sweeper #(.SETTLE_CYCLES(2)) u_dut0 (
`ifdef SWEEP_ERRCNT_EN
    .err_count(ec_s[0]),
`endif
    .clk(clk), .reset(reset), .start(start_s[0]), .abc_out(abc_s[0]), .o_in(o_in_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .fail_vec(fv_s[0]), .table_out(tbl_s[0]));

  four_function_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
`ifdef SWEEP_ERRCNT_EN
    .err_count(ec_s[1]),
`endif
    .clk(clk), .reset(reset), .start(start_s[1]), .abc_out(abc_s[1]), .o_in(o_in_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .fail_vec(fv_s[1]), .table_out(tbl_s[1]));

  four_function_sweeper #(.SETTLE_CYCLES(5)) u_dut2 (
`ifdef SWEEP_ERRCNT_EN
    .err_count(ec_s[2]),
`endif
    .clk(clk), .reset(reset), .start(start_s[2]), .abc_out(abc_s[2]), .o_in(o_in_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .fail_vec(fv_s[2]), .table_out(tbl_s[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int j, input string when);
    chk($sformatf("%s inst%0d abc_out", when, j), 32'(abc_s[j]), 32'd0);
    chk($sformatf("%s inst%0d busy", when, j), 32'(busy_s[j]), 32'd0);
    chk($sformatf("%s inst%0d done", when, j), 32'(done_s[j]), 32'd0);
    chk($sformatf("%s inst%0d pass", when, j), 32'(pass_s[j]), 32'd0);
    chk($sformatf("%s inst%0d fail_vec", when, j), 32'(fv_s[j]), 32'd0);
    chk($sformatf("%s inst%0d table_out", when, j), tbl_s[j], 32'd0);
`ifdef SWEEP_ERRCNT_EN
    chk($sformatf("%s inst%0d err_count", when, j), 32'(ec_s[j]), 32'd0);
`endif
  endtask

  // One full sweep on instance j; expectations come from the fault table and timing rules.
  task automatic run_sweep(input int j, input bit spam);
    int          s, l, p, v, ecnt;
    logic [31:0] etbl, g;
    logic [3:0]  nib;
    logic        epass, found;
    logic [2:0]  efv;
    s = settle(j);
    l = 8 * (s + 1);
    g = GOLD;
    etbl = '0; ecnt = 0; found = 1'b0; efv = '0;
    for (int i = 0; i < 8; i++) begin
      nib = fmask[j][i] ? fval[j][i] : g[4*i +: 4];
      etbl[4*i +: 4] = nib;
      if (nib != g[4*i +: 4]) begin
        ecnt++;
        if (!found) begin
          found = 1'b1;
          efv   = 3'(i);
        end
      end
    end
    epass = (etbl == g);

    @(negedge clk);
    if (have_prev[j]) begin
      chk($sformatf("inst%0d hold table", j), tbl_s[j], prev_tbl[j]);
      chk($sformatf("inst%0d hold pass", j), 32'(pass_s[j]), 32'(prev_pass[j]));
      chk($sformatf("inst%0d hold fail_vec", j), 32'(fv_s[j]), 32'(prev_fv[j]));
    end
    start_s[j] = 1'b1;

    for (int c = 1; c <= l + 1; c++) begin
      @(negedge clk);
      start_s[j] = spam;
      if (c == 1) begin
        chk($sformatf("inst%0d clear table", j), tbl_s[j], 32'd0);
        chk($sformatf("inst%0d clear pass", j), 32'(pass_s[j]), 32'd0);
        chk($sformatf("inst%0d clear fail_vec", j), 32'(fv_s[j]), 32'd0);
      end
      if (c <= l) begin
        p = (c - 1) % (s + 1);
        v = (c - 1) / (s + 1);
        chk($sformatf("inst%0d abc_out c=%0d", j, c), 32'(abc_s[j]), 32'(v));
        chk($sformatf("inst%0d busy c=%0d", j, c), 32'(busy_s[j]), 32'd1);
        chk($sformatf("inst%0d done early c=%0d", j, c), 32'(done_s[j]), 32'd0);
        glitch_s[j] = (p < s) ? 4'($urandom_range(1, 15)) : 4'd0;
      end else begin
        glitch_s[j] = '0;
        chk($sformatf("inst%0d done at %0d", j, c - 1), 32'(done_s[j]), 32'd1);
        chk($sformatf("inst%0d pass", j), 32'(pass_s[j]), 32'(epass));
        chk($sformatf("inst%0d fail_vec", j), 32'(fv_s[j]), 32'(efv));
        chk($sformatf("inst%0d table_out", j), tbl_s[j], etbl);
`ifdef SWEEP_ERRCNT_EN
        chk($sformatf("inst%0d err_count", j), 32'(ec_s[j]), 32'(ecnt));
`endif
      end
    end

    @(negedge clk);
    start_s[j] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("inst%0d single done k=%0d", j, k), 32'(done_s[j]), 32'd0);
      chk($sformatf("inst%0d idle busy k=%0d", j, k), 32'(busy_s[j]), 32'd0);
      chk($sformatf("inst%0d idle abc k=%0d", j, k), 32'(abc_s[j]), 32'd7);
      chk($sformatf("inst%0d idle table k=%0d", j, k), tbl_s[j], etbl);
      chk($sformatf("inst%0d idle pass k=%0d", j, k), 32'(pass_s[j]), 32'(epass));
      @(negedge clk);
    end
    have_prev[j] = 1'b1;
    prev_tbl[j]  = etbl;
    prev_pass[j] = epass;
    prev_fv[j]   = efv;
  endtask

  initial begin
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      start_s[j] = 1'b0; glitch_s[j] = '0; fmask[j] = '0; have_prev[j] = 1'b0;
      prev_tbl[j] = '0; prev_pass[j] = 1'b0; prev_fv[j] = '0;
      for (int i = 0; i < 8; i++) fval[j][i] = '0;
    end
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) chk_zero(j, "reset");
    reset = 1'b0;
    @(negedge clk);

    run_sweep(0, 1'b0);

    fmask[0] = 8'b0100_1000;
    run_sweep(0, 1'b0);
    fmask[0] = '0;

    run_sweep(0, 1'b1);

    // Reset while vector 4 is being driven
    @(negedge clk);
    start_s[0] = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
    end
    chk("inst0 pre-reset abc_out", 32'(abc_s[0]), 32'd4);
    reset = 1'b1;
    #1;
    chk_zero(0, "midsweep reset");
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 3; j++) have_prev[j] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk($sformatf("no done after reset k=%0d", k), 32'(done_s[0]), 32'd0);
    end
    run_sweep(0, 1'b0);

    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);

    // Back-to-back: second sweep faulty on vector 0
    run_sweep(0, 1'b0);
    repeat (3) @(negedge clk);
    fmask[0]   = 8'b0000_0001;
    fval[0][0] = gold_nib(3'd0) ^ 4'h5;
    run_sweep(0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) begin
        fmask[j] = 8'($urandom);
        for (int i = 0; i < 8; i++) fval[j][i] = 4'($urandom);
        run_sweep(j, 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
